frame_scheduler: RTL and testbench

Frame-atomic round-robin scheduler that shares the 32-bit word stream feeding the 1-bit framer's input FIFO among N_REQ payload requesters. It grants one requester for exactly one frame's payload (WORDS_PER_FRAME words). When a granted requester stalls mid-frame it pads the remainder of the frame, so the framer never sees a partially filled payload. It sits between the payload sources (test data FIFO, beacon/control word source) and the framer input FIFO.

---
 rtl/frame_scheduler_pkg.sv | 13 +
 rtl/frame_scheduler_if.sv | 24 ++
 rtl/frame_scheduler_rr_arbiter.sv | 29 ++
 rtl/frame_scheduler.sv | 134 +++++++++++++
 tb/tb_frame_scheduler.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_scheduler_pkg.sv
// Shared types and constants for the frame-atomic round-robin scheduler.
package frame_sched_pkg;
    typedef enum logic [1:0] {ST_ARB, ST_BURST, ST_PAD} sched_state_t;

    localparam int WORD_W             = 32;
    localparam int FRAME_PAYLOAD_BITS = 96;
    localparam logic [WORD_W-1:0] PAD_WORD_DEFAULT = 32'h5555_5555;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/frame_scheduler_if.sv
// Requester and framer-side stream signals plus scheduler status.
interface frame_scheduler_if #(parameter int N_REQ = 2);
    localparam int IW = frame_sched_pkg::idx_w(N_REQ);

    logic [N_REQ-1:0]                        req_valid;
    logic [frame_sched_pkg::WORD_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]                        req_ready;
    logic                                    out_valid;
    logic [frame_sched_pkg::WORD_W-1:0]       out_data;
    logic                                    out_ready;
    logic [IW-1:0]                           grant_id;
    logic                                    frame_active;
    logic                                    pad_event;
    logic [15:0]                             pad_count;

    modport master (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, grant_id, frame_active, pad_event, pad_count
    );
    modport slave (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, grant_id, frame_active, pad_event, pad_count
    );
endinterface

// File: rtl/frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module rr_arbiter import frame_sched_pkg::*; #(
    parameter int N = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/frame_scheduler.sv
// Grants one requester per frame payload; pads the frame tail if the grantee starves.
module frame_scheduler import frame_sched_pkg::*; #(
    parameter int                N_REQ           = 2,
    parameter int                WORDS_PER_FRAME = 3,
    parameter int                STALL_TIMEOUT   = 64,
    parameter logic [WORD_W-1:0] PAD_WORD        = PAD_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    frame_scheduler_if.master  bus
);
    localparam int IW  = idx_w(N_REQ);
    localparam int WCW = $clog2(WORDS_PER_FRAME + 1);
    localparam int SCW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [WCW-1:0] LAST_WORD  = WCW'(WORDS_PER_FRAME - 1);
    localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_TIMEOUT - 1);
    localparam logic [SCW-1:0] STALL_MAX  = SCW'(STALL_TIMEOUT);

    sched_state_t      state, state_next;
    logic [IW-1:0]     rr_ptr, grant_id, next_ptr, arb_idx;
    logic [N_REQ-1:0]  arb_gnt, grant_oh, req_ready;
    logic              arb_any;
    logic [WCW-1:0]    word_cnt;
    logic [SCW-1:0]    stall_cnt;
    logic [15:0]       pad_count;
    logic              pad_event;
    logic [WORD_W-1:0] data_arr [N_REQ];
    logic [WORD_W-1:0] out_data;
    logic              out_valid, g_valid, xfer, starved, last_word, timeout;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = bus.req_data[WORD_W*i +: WORD_W];
    end

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign g_valid   = |(bus.req_valid & grant_oh);
    assign last_word = (word_cnt == LAST_WORD);
    assign timeout   = (stall_cnt == STALL_LAST);
    assign next_ptr  = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_ARB;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_data   = '0;
        req_ready  = '0;
        xfer       = 1'b0;
        starved    = 1'b0;
        case (state)
            ST_ARB: begin
                if (arb_any) state_next = ST_BURST;
            end
            ST_BURST: begin
                out_valid = g_valid;
                out_data  = data_arr[grant_id];
                req_ready = grant_oh & {N_REQ{bus.out_ready}};
                xfer      = g_valid & bus.out_ready;
                starved   = !g_valid;
                if (xfer && last_word)     state_next = ST_ARB;
                else if (starved && timeout) state_next = ST_PAD;
            end
            ST_PAD: begin
                out_valid = 1'b1;
                out_data  = PAD_WORD;
                xfer      = bus.out_ready;
                if (xfer && last_word) state_next = ST_ARB;
            end
            default: state_next = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            grant_oh  <= '0;
            word_cnt  <= '0;
            stall_cnt <= '0;
            pad_count <= '0;
            pad_event <= 1'b0;
        end else begin
            pad_event <= (state == ST_BURST) && (state_next == ST_PAD);
            case (state)
                ST_ARB: begin
                    if (arb_any) begin
                        grant_id  <= arb_idx;
                        grant_oh  <= arb_gnt;
                        word_cnt  <= '0;
                        stall_cnt <= '0;
                    end
                end
                ST_BURST: begin
                    // Backpressure with valid held high neither counts nor clears.
                    if (xfer) begin
                        word_cnt  <= word_cnt + WCW'(1);
                        stall_cnt <= '0;
                    end else if (starved && stall_cnt != STALL_MAX) begin
                        stall_cnt <= stall_cnt + SCW'(1);
                    end
                    if (xfer && last_word) rr_ptr <= next_ptr;
                end
                ST_PAD: begin
                    if (xfer) begin
                        word_cnt <= word_cnt + WCW'(1);
                        if (last_word) begin
                            rr_ptr <= next_ptr;
                            if (pad_count != 16'hFFFF) pad_count <= pad_count + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_data     = out_data;
    assign bus.grant_id     = grant_id;
    assign bus.frame_active = (state != ST_ARB);
    assign bus.pad_event    = pad_event;
    assign bus.pad_count    = pad_count;
endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with a per-cycle frame-level reference model.
module tb_frame_scheduler;
    localparam int N   = 2;
    localparam int W   = 3;
    localparam int TO  = 64;
    localparam logic [31:0] PAD = 32'h5555_5555;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_scheduler_if #(.N_REQ(N)) bus();

    frame_scheduler #(
        .N_REQ(N), .WORDS_PER_FRAME(W), .STALL_TIMEOUT(TO), .PAD_WORD(PAD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [N-1:0]    vld = '0;
    logic            ordy = 1'b1;
    logic            src_clr = 1'b0;
    int              src_idx [N];
    logic [N*32-1:0] data_bus;

    function automatic logic [31:0] word_of(int i, int k);
        return 32'hA000_0000 + (32'(i) << 28) + 32'(k);
    endfunction

    always_comb begin
        data_bus = '0;
        for (int i = 0; i < N; i++) data_bus[32*i +: 32] = word_of(i, src_idx[i]);
    end
    assign bus.req_valid = vld;
    assign bus.req_data  = data_bus;
    assign bus.out_ready = ordy;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sources advance to their next word after each accepted transfer.
    initial for (int i = 0; i < N; i++) src_idx[i] = 0;
    always begin
        logic [N-1:0] pop;
        @(negedge clk);
        pop = bus.req_ready & vld;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (src_clr)     src_idx[i] = 0;
            else if (pop[i]) src_idx[i] = src_idx[i] + 1;
        end
    end

    typedef struct packed {
        logic [31:0] data;
        int          gid;
        int          cyc;
    } xfer_t;
    xfer_t xlog [$];
    int    pad_pulses = 0;
    int    cyc = 0;

    function automatic logic [31:0] xd(int k);
        return (k < xlog.size()) ? xlog[k].data : 32'hDEAD_BEEF;
    endfunction
    function automatic int xg(int k);
        return (k < xlog.size()) ? xlog[k].gid : -1;
    endfunction
    function automatic int xc(int k);
        return (k < xlog.size()) ? xlog[k].cyc : -1000;
    endfunction

    // Reference model: frame in progress, which requester, words delivered,
    // consecutive starved cycles, and whether the tail is being padded.
    bit m_busy, m_pad, m_pev;
    int m_g, m_sent, m_starve, m_ptr, m_npad;

    always begin
        logic        e_ov;
        logic [31:0] e_od;
        logic [N-1:0] e_rdy;
        bit          found;
        int          cand;
        @(negedge clk);
        cyc++;
        if (rst) begin
            m_busy = 0; m_pad = 0; m_pev = 0;
            m_g = 0; m_sent = 0; m_starve = 0; m_ptr = 0; m_npad = 0;
        end else begin
            e_ov  = 1'b0;
            e_od  = '0;
            e_rdy = '0;
            if (m_busy && !m_pad) begin
                e_ov       = vld[m_g];
                e_od       = word_of(m_g, src_idx[m_g]);
                e_rdy[m_g] = ordy;
            end else if (m_busy) begin
                e_ov = 1'b1;
                e_od = PAD;
            end
            chk("cyc_out_valid",    bus.out_valid,    e_ov);
            chk("cyc_out_data",     bus.out_data,     e_od);
            chk("cyc_req_ready",    bus.req_ready,    e_rdy);
            chk("cyc_grant_id",     bus.grant_id,     m_g);
            chk("cyc_frame_active", bus.frame_active, m_busy);
            chk("cyc_pad_event",    bus.pad_event,    m_pev);
            chk("cyc_pad_count",    bus.pad_count,    m_npad);
            if (bus.out_valid && ordy) xlog.push_back('{bus.out_data, int'(bus.grant_id), cyc});
            if (bus.pad_event) pad_pulses++;

            m_pev = 0;
            if (!m_busy) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    cand = (m_ptr + k) % N;
                    if (!found && vld[cand]) begin
                        found = 1; m_g = cand; m_busy = 1; m_sent = 0; m_starve = 0;
                    end
                end
            end else if (!m_pad) begin
                if (vld[m_g] && ordy) begin
                    m_sent++;
                    m_starve = 0;
                end else if (!vld[m_g]) begin
                    m_starve++;
                    if (m_starve == TO) begin m_pad = 1; m_pev = 1; end
                end
                if (m_sent == W) begin m_busy = 0; m_ptr = (m_g + 1) % N; end
            end else if (ordy) begin
                m_sent++;
                if (m_sent == W) begin
                    m_busy = 0; m_pad = 0; m_npad++; m_ptr = (m_g + 1) % N;
                end
            end
        end
    end

    task automatic do_reset();
        vld = '0;
        ordy = 1'b1;
        rst = 1'b1;
        src_clr = 1'b1;
        repeat (3) tick();
        src_clr = 1'b0;
        tick();
        rst = 1'b0;
        xlog.delete();
        pad_pulses = 0;
    endtask

    task automatic wait_xfers(int n, string nm);
        int t = 0;
        while (xlog.size() < n && t < 2000) begin
            tick();
            t++;
        end
        if (xlog.size() < n) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s timeout: got %0d transfers required %0d", nm, xlog.size(), n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp6 [6];
        exp6 = '{32'hA000_0000, 32'h5555_5555, 32'h5555_5555,
                 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};

        // Reset state
        do_reset();
        chk("rst_out_valid",    bus.out_valid,    0);
        chk("rst_out_data",     bus.out_data,     0);
        chk("rst_req_ready",    bus.req_ready,    0);
        chk("rst_grant_id",     bus.grant_id,     0);
        chk("rst_frame_active", bus.frame_active, 0);
        chk("rst_pad_event",    bus.pad_event,    0);
        chk("rst_pad_count",    bus.pad_count,    0);

        // Single source: A0 A1 A2, gap, A3 A4 A5
        vld = 2'b01;
        wait_xfers(6, "t1");
        vld = '0;
        for (int k = 0; k < 6; k++) begin
            chk("t1_data",  xd(k), 32'hA000_0000 + 32'(k));
            chk("t1_grant", xg(k), 0);
        end
        chk("t1_burst_span", xc(2) - xc(0), 2);
        chk("t1_gap",        xc(3) - xc(2), 2);
        chk("t1_pad_count",  bus.pad_count, 0);

        // Two sources always valid: frames alternate 0,1,0,1
        do_reset();
        vld = 2'b11;
        wait_xfers(12, "t2");
        vld = '0;
        for (int f = 0; f < 4; f++) begin
            for (int w = 0; w < 3; w++) begin
                chk("t2_grant", xg(3*f + w), f % 2);
                chk("t2_data",  xd(3*f + w), ((f % 2) ? 32'hB000_0000 : 32'hA000_0000) + 32'((f / 2) * 3 + w));
            end
        end

        // Mid-frame stall: B0 then two pad words
        do_reset();
        vld = 2'b10;
        wait_xfers(1, "t3a");
        vld = '0;
        wait_xfers(3, "t3b");
        repeat (3) tick();
        chk("t3_w0",         xd(0), 32'hB000_0000);
        chk("t3_w1",         xd(1), PAD);
        chk("t3_w2",         xd(2), PAD);
        chk("t3_pad_delay",  xc(1) - xc(0), 65);
        chk("t3_pad_grant",  xg(2), 1);
        chk("t3_pad_pulses", pad_pulses, 1);
        chk("t3_pad_count",  bus.pad_count, 1);

        // Backpressure for 200 cycles: no pad, frame completes afterwards
        do_reset();
        vld = 2'b01;
        wait_xfers(1, "t4a");
        ordy = 1'b0;
        repeat (200) tick();
        chk("t4_hold_data",  bus.out_data, 32'hA000_0001);
        chk("t4_no_pad",     pad_pulses, 0);
        ordy = 1'b1;
        wait_xfers(3, "t4b");
        vld = '0;
        for (int k = 0; k < 3; k++) chk("t4_data", xd(k), 32'hA000_0000 + 32'(k));
        chk("t4_resume",     xc(1) - xc(0), 201);
        chk("t4_pad_count",  bus.pad_count, 0);

        // Async reset mid-burst of requester 1; arbitration restarts at requester 0
        do_reset();
        vld = 2'b11;
        wait_xfers(4, "t5a");
        chk("t5_pre_valid",  bus.out_valid, 1);
        chk("t5_pre_grant",  bus.grant_id, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_valid",  bus.out_valid, 0);
        chk("t5_rst_ready",  bus.req_ready, 0);
        chk("t5_rst_active", bus.frame_active, 0);
        chk("t5_rst_data",   bus.out_data, 0);
        repeat (2) tick();
        rst = 1'b0;
        xlog.delete();
        wait_xfers(1, "t5b");
        chk("t5_regrant",    xg(0), 0);
        chk("t5_resume",     xd(0), 32'hA000_0003);

        // Valid returns in the first pad cycle: padding wins, word kept
        vld = '0;
        do_reset();
        vld = 2'b01;
        wait_xfers(1, "t6a");
        vld = '0;
        repeat (TO) tick();
        vld = 2'b01;
        chk("t6_entry_data",  bus.out_data, PAD);
        chk("t6_entry_event", bus.pad_event, 1);
        chk("t6_entry_ready", bus.req_ready, 0);
        wait_xfers(6, "t6b");
        vld = '0;
        repeat (2) tick();
        for (int k = 0; k < 6; k++) chk("t6_data", xd(k), exp6[k]);
        chk("t6_pad_count",  bus.pad_count, 1);
        chk("t6_pad_pulses", pad_pulses, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
